// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Shares one W-bit unsigned multiplier between two MIX requesters
//   (0: CPU MUL, 1: address/IO unit). It takes sign-magnitude MIX words and
//   arbitrates round-robin. It also sequences the multiplier start strobe and
//   its fixed latency. The sign-magnitude double word is returned as rA:rX.
//
//   Parameters
//     W        magnitude width of one MIX word (full word is W+1 bits, sign at bit W)
//     MUL_LAT  edges after the edge that samples mul_start until mul_c is final (2..15)
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     req0, a0, b0        requester 0: request (held until done0), operands
//     done0               one-cycle pulse, ra/rx valid for requester 0
//     req1, a1, b1, done1 requester 1, same meaning
//     ra, rx              {sign, product[2W-1:W]}, {sign, product[W-1:0]}
//     busy                high whenever the arbiter is not idle
//     mul_start           one-cycle start strobe to the multiplier
//     mul_a, mul_b        multiplier operand magnitudes, stable from grant to next grant
//     mul_c               multiplier product
//
//   Build option
//     MUL_ARB_ZERO_SKIP_EN  when defined, a granted pair with a zero magnitude
//                           bypasses the multiplier and completes two edges after
//                           the request with {sign, 0}.

module mul_arbiter #(
    parameter int W       = 30,
    parameter int MUL_LAT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [W:0]       a0,
    input  logic [W:0]       b0,
    output logic             done0,
    input  logic             req1,
    input  logic [W:0]       a1,
    input  logic [W:0]       b1,
    output logic             done1,
    output logic [W:0]       ra,
    output logic [W:0]       rx,
    output logic             busy,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_c
);

    localparam logic [2:0] ST_FLUSH = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_CAP   = 3'd4;

    localparam logic [3:0] CNT_LAT  = 4'(MUL_LAT);
    localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

    logic [2:0]   state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic         owner_reg, owner_next;
    logic         last_reg, last_next;
    logic         sign_reg, sign_next;
    logic [W-1:0] mul_a_reg, mul_a_next;
    logic [W-1:0] mul_b_reg, mul_b_next;
    logic [W:0]   ra_reg, ra_next;
    logic [W:0]   rx_reg, rx_next;
`ifdef MUL_ARB_ZERO_SKIP_EN
    logic         zero_reg, zero_next;
`endif

    // Round-robin choice: a lone request wins outright; on a tie the
    // requester that was not served last wins (last resets to 1, so the
    // first tie goes to requester 0).
    logic         grant_owner;
    logic [W:0]   sel_a, sel_b;

    always_comb begin
        grant_owner = req1;
        if (req0 && req1) begin
            grant_owner = ~last_reg;
        end
    end

    assign sel_a = grant_owner ? a1 : a0;
    assign sel_b = grant_owner ? b1 : b0;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        sign_next  = sign_reg;
        mul_a_next = mul_a_reg;
        mul_b_next = mul_b_reg;
        ra_next    = ra_reg;
        rx_next    = rx_reg;
`ifdef MUL_ARB_ZERO_SKIP_EN
        zero_next  = zero_reg;
`endif
        case (state_reg)
            // The multiplier has no reset and may still be mid-run after
            // rst_n; wait out a full latency before any new start.
            ST_FLUSH: begin
                if (cnt_reg == CNT_LAT) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_next = grant_owner;
                    last_next  = grant_owner;
                    sign_next  = sel_a[W] ^ sel_b[W];
                    mul_a_next = sel_a[W-1:0];
                    mul_b_next = sel_b[W-1:0];
`ifdef MUL_ARB_ZERO_SKIP_EN
                    zero_next  = (sel_a[W-1:0] == '0) || (sel_b[W-1:0] == '0);
                    state_next = zero_next ? ST_CAP : ST_LOAD;
`else
                    state_next = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                cnt_next   = 4'd0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_CAP;
                end
            end
            ST_CAP: begin
                // mul_c is final during this cycle. The sign is kept even
                // for a zero product (-0 is a legal MIX result).
                ra_next    = {sign_reg, mul_c[2*W-1:W]};
                rx_next    = {sign_reg, mul_c[W-1:0]};
`ifdef MUL_ARB_ZERO_SKIP_EN
                if (zero_reg) begin
                    ra_next = {sign_reg, {W{1'b0}}};
                    rx_next = {sign_reg, {W{1'b0}}};
                end
`endif
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_FLUSH;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FLUSH;
            cnt_reg   <= 4'd0;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            sign_reg  <= 1'b0;
            mul_a_reg <= '0;
            mul_b_reg <= '0;
            ra_reg    <= '0;
            rx_reg    <= '0;
`ifdef MUL_ARB_ZERO_SKIP_EN
            zero_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            sign_reg  <= sign_next;
            mul_a_reg <= mul_a_next;
            mul_b_reg <= mul_b_next;
            ra_reg    <= ra_next;
            rx_reg    <= rx_next;
`ifdef MUL_ARB_ZERO_SKIP_EN
            zero_reg  <= zero_next;
`endif
        end
    end

    // One done flop per requester, pulsed on the CAP edge for the owner.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_done
            logic done_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    done_reg <= 1'b0;
                end else begin
                    done_reg <= (state_reg == ST_CAP) && (owner_reg == 1'(gi));
                end
            end
        end
    endgenerate

    assign done0     = g_done[0].done_reg;
    assign done1     = g_done[1].done_reg;
    assign ra        = ra_reg;
    assign rx        = rx_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign mul_start = (state_reg == ST_LOAD);
    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;

endmodule
